// File: rtl/vdff_en.sv
`default_nettype none
// ============================================================================
// Module      : vdff_en
// Description : Parameterized-width D register with sync reset and load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module vdff_en #(
    parameter int unsigned n         = 1,
    parameter logic [n-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [n-1:0] in,
    output logic [n-1:0] out
);

    logic [n-1:0] out_q;
    logic [n-1:0] out_d;

    // Reset outranks a same-edge load; with en low the register holds.
    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d = in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= RESET_VAL;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_vdff_en.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdff_en
// Description : Directed self-checking bench for vdff_en (n=8, n=1, n=4/RESET_VAL=B).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdff_en;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, en8;
    logic [7:0] in8, out8;
    logic       rst1, en1, in1, out1;
    logic       rst4, en4;
    logic [3:0] in4, out4;

    int total = 0;
    int bad   = 0;

    vdff_en #(.n(8)) u_dut8 (
        .clk(clk), .rst(rst8), .en(en8), .in(in8), .out(out8)
    );

    vdff_en u_dut1 (
        .clk(clk), .rst(rst1), .en(en1), .in(in1), .out(out1)
    );

    vdff_en #(.n(4), .RESET_VAL(4'hB)) u_dut4 (
        .clk(clk), .rst(rst4), .en(en4), .in(in4), .out(out4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst8 = 1'b1; en8 = 1'b1; in8 = 8'hA5;
        rst1 = 1'b1; en1 = 1'b1; in1 = 1'b1;
        rst4 = 1'b1; en4 = 1'b0; in4 = 4'h0;

        // Reset with en high, then with en low
        step();
        check("rst_en1", 64'(out8), 64'h00);
        check("rst_w1", 64'(out1), 64'h0);
        check("rst_val4", 64'(out4), 64'hB);
        en8 = 1'b0;
        step();
        check("rst_en0", 64'(out8), 64'h00);

        // Load then hold for three edges
        rst8 = 1'b0; en8 = 1'b1; in8 = 8'h3C;
        step();
        check("load_3c", 64'(out8), 64'h3C);
        en8 = 1'b0; in8 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_3c", 64'(out8), 64'h3C);
        end

        // Tracking with one-cycle latency; mid-cycle input changes are invisible
        en8 = 1'b1; in8 = 8'h01;
        step();
        check("track_01", 64'(out8), 64'h01);
        in8 = 8'h02;
        #2;
        check("mid_cycle", 64'(out8), 64'h01);
        step();
        check("track_02", 64'(out8), 64'h02);
        in8 = 8'h03;
        step();
        check("track_03", 64'(out8), 64'h03);

        // Reset beats a same-edge load, next edge loads normally
        in8 = 8'h3C;
        step();
        check("reload_3c", 64'(out8), 64'h3C);
        rst8 = 1'b1; en8 = 1'b1; in8 = 8'h55;
        step();
        check("rst_prio", 64'(out8), 64'h00);
        rst8 = 1'b0;
        step();
        check("post_rst_55", 64'(out8), 64'h55);

        // Default width n=1
        rst1 = 1'b0; en1 = 1'b1; in1 = 1'b1;
        step();
        check("w1_load", 64'(out1), 64'h1);
        en1 = 1'b0; in1 = 1'b0;
        step();
        check("w1_hold", 64'(out1), 64'h1);
        rst1 = 1'b1;
        step();
        check("w1_rst", 64'(out1), 64'h0);

        // Non-zero RESET_VAL
        rst4 = 1'b0; en4 = 1'b1; in4 = 4'h2;
        step();
        check("rv4_load", 64'(out4), 64'h2);
        en4 = 1'b0; in4 = 4'h7;
        step();
        check("rv4_hold", 64'(out4), 64'h2);
        rst4 = 1'b1; en4 = 1'b1; in4 = 4'hF;
        step();
        check("rv4_rst", 64'(out4), 64'hB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
